// File: rtl/stopwatch_pkg.sv
// Shared types and BCD digit helpers for the mm:ss stopwatch.
// Digit step functions return {carry_or_borrow, next_digit}; pure combinational, no flow control.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_T_MAX = 4'd5;
    localparam bcd_t BCD_MAX   = 4'd9;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ADJ_SEC = 2'd1,
        ADJ_MIN = 2'd2
    } mode_t;

    typedef struct packed {
        bcd_t min_t;
        bcd_t min_o;
        bcd_t sec_t;
        bcd_t sec_o;
    } mmss_t;

    function automatic logic [4:0] bcd_inc(input bcd_t d, input bcd_t max);
        return (d >= max) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
    endfunction

    function automatic logic [4:0] bcd_dec(input bcd_t d, input bcd_t max);
        return (d == 4'd0) ? {1'b1, max} : {1'b0, d - 4'd1};
    endfunction

endpackage

// File: rtl/stopwatch_core_tick_div.sv
// Free-running 0..DIV-1 divider with synchronous clear; tick is high while the count sits at DIV-1.
// Latency: tick combinational from the count register; lo_half reflects the next count. No backpressure.
module tick_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic RESET,
    input  logic clr,
    output logic tick,
    output logic lo_half
);

    localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]   LAST = W'(DIV - 1);
    localparam logic [W:0]     HALF = (W+1)'(DIV / 2);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_n;

    always_comb begin
        cnt_n = (clr || cnt == LAST) ? '0 : cnt + W'(1);
    end

    // A clear outranks a coincident terminal count so a mode change never steps immediately.
    assign tick    = !clr && (cnt == LAST);
    assign lo_half = {1'b0, cnt_n} < HALF;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) cnt <= '0;
        else       cnt <= cnt_n;
    end

endmodule

// File: rtl/stopwatch_core.sv
// mm:ss stopwatch engine: run/adjust dividers, BCD up/down counting, pause, auto-stop, blink; optional lap hold (STOPWATCH_LAP_EN).
// Latency: every output registered, digits change the cycle after a tick. No backpressure; inputs sampled every cycle.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int RUN_HZ  = 1,
    parameter int ADJ_HZ  = 2,
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       ADJ,
    input  logic       SEL,
    input  logic       DOWN,
    input  logic       PAUSE,
`ifdef STOPWATCH_LAP_EN
    input  logic       LAP,
    output logic       lap_hold,
`endif
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       paused,
    output logic       tc,
    output logic       blink
);

    localparam int   RUN_DIV   = CLK_HZ / RUN_HZ;
    localparam int   ADJ_DIV   = CLK_HZ / ADJ_HZ;
    localparam bcd_t MIN_T_MAX = bcd_t'(MIN_MAX / 10);
    localparam bcd_t MIN_O_MAX = bcd_t'(MIN_MAX % 10);

    if (MIN_MAX < 1 || MIN_MAX > 99) begin : g_min_max_check
        $error("stopwatch_core: MIN_MAX must be within 1..99");
    end

    logic  adj_q, sel_q, chg;
    logic  run_tick, adj_tick, adj_lo_half;
    mmss_t cur, nxt;
    mode_t mode;
    logic  paused_n, tc_n;

    logic  so_c, st_c, mo_c, so_b, st_b, mo_b;
    bcd_t  so_up, st_up, mo_up, so_dn, st_dn, mo_dn;
    logic  min_top, at_zero, at_one;
    bcd_t  min_up_t, min_up_o;

    assign chg = (ADJ != adj_q) || (SEL != sel_q);

    tick_div #(.DIV(RUN_DIV)) u_run_div (
        .clk(clk), .RESET(RESET), .clr(chg), .tick(run_tick), .lo_half()
    );

    tick_div #(.DIV(ADJ_DIV)) u_adj_div (
        .clk(clk), .RESET(RESET), .clr(chg), .tick(adj_tick), .lo_half(adj_lo_half)
    );

    assign {so_c, so_up} = bcd_inc(cur.sec_o, BCD_MAX);
    assign {st_c, st_up} = bcd_inc(cur.sec_t, SEC_T_MAX);
    assign {mo_c, mo_up} = bcd_inc(cur.min_o, BCD_MAX);
    assign {so_b, so_dn} = bcd_dec(cur.sec_o, BCD_MAX);
    assign {st_b, st_dn} = bcd_dec(cur.sec_t, SEC_T_MAX);
    assign {mo_b, mo_dn} = bcd_dec(cur.min_o, BCD_MAX);

    assign min_top  = (cur.min_t == MIN_T_MAX) && (cur.min_o == MIN_O_MAX);
    assign at_zero  = (cur == '0);
    assign at_one   = (cur == mmss_t'(16'h0001));
    assign min_up_o = min_top ? 4'd0 : mo_up;
    assign min_up_t = min_top ? 4'd0 : (mo_c ? cur.min_t + 4'd1 : cur.min_t);

    always_comb begin
        mode     = !ADJ ? RUN : (SEL ? ADJ_MIN : ADJ_SEC);
        nxt      = cur;
        paused_n = paused ^ PAUSE;
        tc_n     = 1'b0;
        unique case (mode)
            RUN: begin
                // The tick tests the pre-toggle paused value.
                if (run_tick && !paused) begin
                    if (!DOWN) begin
                        nxt.sec_o = so_up;
                        if (so_c) begin
                            nxt.sec_t = st_up;
                            if (st_c) begin
                                nxt.min_o = min_up_o;
                                nxt.min_t = min_up_t;
                                tc_n      = min_top;
                            end
                        end
                    end else if (!at_zero) begin
                        nxt.sec_o = so_dn;
                        if (so_b) begin
                            nxt.sec_t = st_dn;
                            if (st_b) begin
                                nxt.min_o = mo_dn;
                                if (mo_b) nxt.min_t = cur.min_t - 4'd1;
                            end
                        end
                        if (at_one) begin
                            tc_n     = 1'b1;
                            paused_n = 1'b1;
                        end
                    end
                end
            end
            ADJ_SEC: begin
                if (adj_tick) begin
                    nxt.sec_o = so_up;
                    if (so_c) nxt.sec_t = st_up;
                end
            end
            ADJ_MIN: begin
                if (adj_tick) begin
                    nxt.min_o = min_up_o;
                    nxt.min_t = min_up_t;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cur    <= '0;
            paused <= 1'b0;
            tc     <= 1'b0;
            blink  <= 1'b0;
            adj_q  <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            cur    <= nxt;
            paused <= paused_n;
            tc     <= tc_n;
            blink  <= ADJ & adj_lo_half;
            adj_q  <= ADJ;
            sel_q  <= SEL;
        end
    end

`ifdef STOPWATCH_LAP_EN
    mmss_t lap_q, disp;
    logic  hold_n, grab;

    assign grab   = LAP && !lap_hold;
    assign hold_n = ADJ ? 1'b0 : (LAP ? !lap_hold : lap_hold);

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            lap_q    <= '0;
            lap_hold <= 1'b0;
            disp     <= '0;
        end else begin
            if (grab) lap_q <= cur;
            lap_hold <= hold_n;
            disp     <= hold_n ? (grab ? cur : lap_q) : nxt;
        end
    end

    assign {min_t, min_o, sec_t, sec_o} = disp;
`else
    assign {min_t, min_o, sec_t, sec_o} = cur;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core at CLK_HZ=8, RUN_HZ=1, ADJ_HZ=2, MIN_MAX=59.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       RESET, ADJ, SEL, DOWN, PAUSE;
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic       paused, tc, blink;
    logic [15:0] shown;
`ifdef STOPWATCH_LAP_EN
    logic       LAP, lap_hold;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_core #(.CLK_HZ(8), .RUN_HZ(1), .ADJ_HZ(2), .MIN_MAX(59)) dut (
        .clk(clk), .RESET(RESET), .ADJ(ADJ), .SEL(SEL), .DOWN(DOWN), .PAUSE(PAUSE),
`ifdef STOPWATCH_LAP_EN
        .LAP(LAP), .lap_hold(lap_hold),
`endif
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
        .paused(paused), .tc(tc), .blink(blink)
    );

    assign shown = {min_t, min_o, sec_t, sec_o};

    typedef struct {
        logic [3:0]  in;   // {ADJ, SEL, DOWN, PAUSE-pulse}
        int          cyc;
        logic [15:0] t;    // expected mm:ss as BCD
        logic [2:0]  pcb;  // expected {paused, tc, blink}
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] t, input logic p, input logic c, input logic b);
        chk16({tag, ".time"}, shown, t);
        chk1({tag, ".paused"}, paused, p);
        chk1({tag, ".tc"}, tc, c);
        chk1({tag, ".blink"}, blink, b);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'b0000,    7, 16'h0000, 3'b000};
        vecs[1]  = '{4'b0000,    1, 16'h0001, 3'b000};
        vecs[2]  = '{4'b0000,   72, 16'h0010, 3'b000};
        vecs[3]  = '{4'b0000,  400, 16'h0100, 3'b000};
        vecs[4]  = '{4'b0000, 4320, 16'h1000, 3'b000};
        vecs[5]  = '{4'b0010,    8, 16'h0959, 3'b000};
        vecs[6]  = '{4'b0000,    8, 16'h1000, 3'b000};
        vecs[7]  = '{4'b1100,    5, 16'h1100, 3'b001};
        vecs[8]  = '{4'b1100,  188, 16'h5800, 3'b001};
        vecs[9]  = '{4'b1100,    4, 16'h5900, 3'b001};
        vecs[10] = '{4'b1000,    5, 16'h5901, 3'b001};
        vecs[11] = '{4'b1000,  232, 16'h5959, 3'b001};
        vecs[12] = '{4'b0000,    8, 16'h5959, 3'b000};
        vecs[13] = '{4'b0000,    1, 16'h0000, 3'b010};
        vecs[14] = '{4'b0000,    1, 16'h0000, 3'b000};
        vecs[15] = '{4'b0000,    7, 16'h0001, 3'b000};
        vecs[16] = '{4'b0000,    8, 16'h0002, 3'b000};
        vecs[17] = '{4'b0010,    8, 16'h0001, 3'b000};
        vecs[18] = '{4'b0010,    8, 16'h0000, 3'b110};
        vecs[19] = '{4'b0010,    1, 16'h0000, 3'b100};
        vecs[20] = '{4'b0011,    1, 16'h0000, 3'b000};
        vecs[21] = '{4'b0010,   40, 16'h0000, 3'b000};
        vecs[22] = '{4'b0000,    6, 16'h0001, 3'b000};
        vecs[23] = '{4'b0000,   24, 16'h0004, 3'b000};
        vecs[24] = '{4'b0000,    8, 16'h0005, 3'b000};

        RESET = 1'b1; ADJ = 1'b0; SEL = 1'b0; DOWN = 1'b0; PAUSE = 1'b0;
`ifdef STOPWATCH_LAP_EN
        LAP = 1'b0;
`endif
        #12;
        chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        #10 RESET = 1'b0;

        for (int i = 0; i < NV; i++) begin
            {ADJ, SEL, DOWN, PAUSE} = vecs[i].in;
            if (vecs[i].in[0]) begin
                step(1);
                PAUSE = 1'b0;
                if (vecs[i].cyc > 1) step(vecs[i].cyc - 1);
            end else begin
                step(vecs[i].cyc);
            end
            chk_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].pcb[2], vecs[i].pcb[1], vecs[i].pcb[0]);
        end

        // PAUSE coinciding with a run tick: the tick still lands, then the count freezes.
        step(7);
        chk16("pz_pre", shown, 16'h0005);
        PAUSE = 1'b1; step(1); PAUSE = 1'b0;
        chk16("pz_tick", shown, 16'h0006);
        chk1("pz_paused", paused, 1'b1);
        step(16);
        chk16("pz_frozen", shown, 16'h0006);
        PAUSE = 1'b1; step(1); PAUSE = 1'b0;
        chk1("pz_resume", paused, 1'b0);
        step(7);
        chk16("pz_run", shown, 16'h0007);

        // Auto-stop and PAUSE in the same cycle must leave the timer paused.
        DOWN = 1'b1;
        step(48);
        chk16("as_pre", shown, 16'h0001);
        step(7);
        PAUSE = 1'b1; step(1); PAUSE = 1'b0;
        chk_all("as_pause", 16'h0000, 1'b1, 1'b1, 1'b0);

        // Adjust ignores paused and DOWN; minutes wrap at MIN_MAX; SEL toggles restart the divider.
        ADJ = 1'b1; SEL = 1'b1;
        step(5);
        chk16("am_first", shown, 16'h0100);
        step(232);
        chk16("am_59", shown, 16'h5900);
        SEL = 1'b0;
        step(121);
        chk16("as_30", shown, 16'h5930);
        SEL = 1'b1; step(3);
        chk_all("sel_a", 16'h5930, 1'b1, 1'b0, 1'b0);
        SEL = 1'b0; step(1);
        chk_all("sel_b", 16'h5930, 1'b1, 1'b0, 1'b1);
        SEL = 1'b1; step(1);
        chk16("sel_c", shown, 16'h5930);
        step(3);
        chk_all("sel_d", 16'h5930, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_all("min_wrap", 16'h0030, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk1($sformatf("blink%0d", i), blink, (i % 4) < 2);
        end
        chk16("blink_end", shown, 16'h0230);

        step(40);
        SEL = 1'b0;
        step(17);
        chk16("pre_12_34", shown, 16'h1234);
        ADJ = 1'b0; DOWN = 1'b0;
        PAUSE = 1'b1; step(1); PAUSE = 1'b0;
        chk1("unpause", paused, 1'b0);
        step(3);
        chk16("hold_12_34", shown, 16'h1234);
        #3 RESET = 1'b1;
        #1;
        chk_all("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        #2 RESET = 1'b0;
        step(8);
        chk16("post_rst", shown, 16'h0001);

`ifdef STOPWATCH_LAP_EN
        chk1("lap_idle", lap_hold, 1'b0);
        step(16);
        chk16("lap_pre", shown, 16'h0003);
        LAP = 1'b1; step(1); LAP = 1'b0;
        chk1("lap_on", lap_hold, 1'b1);
        step(23);
        chk16("lap_held", shown, 16'h0003);
        LAP = 1'b1; step(1); LAP = 1'b0;
        chk1("lap_off", lap_hold, 1'b0);
        chk16("lap_live", shown, 16'h0006);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
